rs485_master_poller: RTL and testbench
======================================

# rs485_master_poller

Bus-master end of the RS485 9-bit multidrop polling link. On a `start` request it transmits one address frame (9th bit = 1) to a slave, releases the bus, then receives that slave's 16-bit reply as two data frames (9th bit = 0). It checks the reply's framing and returns the word to the host logic, or reports an error. It sits between the host-side controller and the RS485 transceiver (DE/DI/RO pins).

## Interface
Parameters:
- `TIMEOUT_BITS`, default 64: bit periods to wait for a reply start bit before declaring a timeout.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  poll request; honoured only when `busy`=0.
- `slave_addr`  in  8  address to poll; latched on accepted `start`.
- `clk_per_bit`  in  8  clocks per bit; latched on accepted `start`; values <4 are treated as 4.
- `rx`  in  1  transceiver RO; asynchronous.
- `tx`  out  1  transceiver DI; idle high.
- `tx_enable`  out  1  transceiver DE; high only while the address frame is driven.
- `busy`  out  1  poll in progress.
- `data_out`  out  16  reply word; holds its value until the next successful poll.
- `data_valid`  out  1  one-cycle pulse when the reply word is good.
- `error`  out  1  one-cycle pulse when the poll fails.
- `err_code`  out  2  cause of failure, valid with `error`, held afterwards: 01 timeout, 10 stop bit low, 11 9th bit = 1 in reply.

## Operation
- Frame format, 11 bits, LSB first: start 0, d0..d7, 9th bit, stop 1.
  - Address frame: 9th bit = 1.
  - Reply: two back-to-back data frames, each with 9th bit = 0. First frame carries `data_out[7:0]`, second carries `data_out[15:8]`.
- `rx` passes through a 2-flop synchronizer. All sampling uses the synchronized signal.
- States:
  - IDLE: `tx`=1, `tx_enable`=0. An accepted `start` latches the inputs and moves to TX_ADDR.
  - TX_ADDR: shifts the 11 address-frame bits, each held `clk_per_bit` clocks. `rx` is ignored (local echo). After the stop bit, moves to WAIT_START with timeout counter = 0 and frame index = 0.
  - WAIT_START: timeout counter increments once per bit period.
    - On synchronized `rx` = 0, move to CHECK_START.
    - If the counter reaches `TIMEOUT_BITS`, signal error 01.
  - CHECK_START: counts `(clk_per_bit-1)/2` clocks to mid-bit, then resamples.
    - Still 0: move to RX_BITS.
    - Otherwise it was a glitch: return to WAIT_START. The timeout counter is not reset.
  - RX_BITS: samples 10 bits (8 data, 9th bit, stop), one every `clk_per_bit` clocks from the start-bit midpoint.
    - 9th bit = 1: error 11.
    - Stop = 0: error 10.
    - When both errors apply, 11 takes priority.
    - Good frame 0: store the low byte, set frame index = 1, reset the timeout counter, go to WAIT_START.
    - Good frame 1: go to DONE.
  - DONE: loads `data_out` with the full word, pulses `data_valid`, returns to IDLE.
- Error path: pulse `error`, load `err_code`, return to IDLE. `data_out` is unchanged.
- Bit-period counter width: 8 bits. It wraps to 0 on reaching `clk_per_bit-1`.

## Timing
- Reset values: `tx`=1, `tx_enable`=0, `busy`=0, `data_out`=0, `data_valid`=0, `error`=0, `err_code`=00.
- Reset asserted mid-poll: the next cycle is IDLE with reset values. No pulse is generated.
- `start` sampled high in IDLE at cycle N:
  - `busy`=1, `tx_enable`=1 and `tx`=0 from cycle N+1.
  - Address bit k occupies cycles N+1+k·cpb through N+(k+1)·cpb.
  - `tx_enable`=0 and `tx`=1 from cycle N+1+11·cpb.
- `start` while `busy`=1 is ignored. `start` in the same cycle as the `data_valid`/`error` pulse is also ignored.
- `data_valid`/`error` asserts one cycle after the final stop-bit sample.
- `busy` falls in the same cycle as the `data_valid`/`error` pulse. A `start` can be accepted on the following cycle.
- `data_valid` and `error` are never high together.
- Rx latency: 2 cycles (synchronizer) plus half a bit period to the start-bit check.

## Test plan
- Address timing: `slave_addr`=8'h02, `clk_per_bit`=25, `start` pulse → `tx` sequence 0,0,1,0,0,0,0,0,0,1,1, each bit 25 clocks; `tx_enable` high for exactly 275 cycles.
- Good reply: model slave answers after 10 bit periods with 0,d0..d7,0,1 then 0,d8..d15,0,1 for word 16'hA5C3 → single `data_valid`, `data_out`=16'hA5C3, `error`=0.
- No reply, `TIMEOUT_BITS`=64 → `error` pulse with `err_code`=01 after 64 bit periods; `data_out` keeps the previous value.
- Reply frame 1 with stop bit 0 → `err_code`=10. Separately, reply frame 2 with 9th bit 1 → `err_code`=11. In both cases no `data_valid`.
- Glitch: 5-clock low pulse on `rx` during WAIT_START → ignored; the subsequent valid reply is still received correctly.
- Robustness: `start` re-asserted while `busy` → ignored. Reset mid-RX_BITS → outputs at reset values next cycle, then a fresh poll succeeds. `clk_per_bit`=2 → bits last 4 clocks.

Source files
------------

// File: rtl/rs485_master_poller.sv
// RS485 9-bit multidrop bus master: sends one address frame, releases the
// bus, then receives a two-frame 16-bit reply and reports word or error.
//
// state         | meaning
// --------------+------------------------------------------------------
// S_IDLE        | bus released, tx idle high, waiting for start
// S_TX_ADDR     | driving the 11-bit address frame, tx_enable high
// S_WAIT_START  | listening for a reply start bit, timeout running
// S_CHECK_START | confirming the start bit at its midpoint
// S_RX_BITS     | sampling d0..d7, 9th bit and stop of one reply frame
// S_DONE        | data_valid pulse, data_out already loaded
// S_ERR         | error pulse, err_code already loaded
module rs485_master_poller #(
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  slave_addr,
  input  logic [7:0]  clk_per_bit,
  input  logic        rx,
  output logic        tx,
  output logic        tx_enable,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_ADDR, S_WAIT_START, S_CHECK_START, S_RX_BITS, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [7:0]    cpb_q, cpb_d;
  logic [7:0]    bcnt_q, bcnt_d;
  logic [3:0]    bidx_q, bidx_d;
  logic [10:0]   tsh_q, tsh_d;
  logic [8:0]    rsh_q, rsh_d;
  logic [7:0]    lo_q, lo_d;
  logic          frame_q, frame_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    ecode_q, ecode_d;

  logic          bit_end;
  logic [7:0]    half;

  assign bit_end = (bcnt_q == cpb_q - 8'd1);
  assign half    = (cpb_q - 8'd1) >> 1;

  // Two-flop synchronizer for the asynchronous receive line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cpb_q   <= 8'd4;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      tsh_q   <= '1;
      rsh_q   <= '0;
      lo_q    <= '0;
      frame_q <= 1'b0;
      tout_q  <= '0;
      data_q  <= '0;
      ecode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cpb_q   <= cpb_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      tsh_q   <= tsh_d;
      rsh_q   <= rsh_d;
      lo_q    <= lo_d;
      frame_q <= frame_d;
      tout_q  <= tout_d;
      data_q  <= data_d;
      ecode_q <= ecode_d;
    end
  end

  // Next-state logic; data_out and err_code load on entry to DONE/ERR so
  // they are already valid during the pulse cycle.
  always_comb begin
    state_d = state_q;
    cpb_d   = cpb_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    tsh_d   = tsh_q;
    rsh_d   = rsh_q;
    lo_d    = lo_q;
    frame_d = frame_q;
    tout_d  = tout_q;
    data_d  = data_q;
    ecode_d = ecode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cpb_d   = (clk_per_bit < 8'd4) ? 8'd4 : clk_per_bit;
          tsh_d   = {2'b11, slave_addr, 1'b0};
          bcnt_d  = '0;
          bidx_d  = '0;
          state_d = S_TX_ADDR;
        end
      end
      S_TX_ADDR: begin
        if (bit_end) begin
          bcnt_d = '0;
          tsh_d  = {1'b1, tsh_q[10:1]};
          bidx_d = bidx_q + 4'd1;
          if (bidx_q == 4'd10) begin
            tout_d  = '0;
            frame_d = 1'b0;
            state_d = S_WAIT_START;
          end
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_WAIT_START: begin
        if (!rx_sync_q) begin
          bcnt_d  = '0;
          state_d = S_CHECK_START;
        end else if (bit_end) begin
          bcnt_d = '0;
          tout_d = tout_q + TW'(1);
          if (tout_q == TW'(TIMEOUT_BITS - 1)) begin
            ecode_d = 2'b01;
            state_d = S_ERR;
          end
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_CHECK_START: begin
        if (bcnt_q == half) begin
          bcnt_d = '0;
          bidx_d = '0;
          // a high line at mid-bit means the falling edge was a glitch
          state_d = rx_sync_q ? S_WAIT_START : S_RX_BITS;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_RX_BITS: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (bidx_q == 4'd9) begin
            if (rsh_q[8]) begin
              ecode_d = 2'b11;
              state_d = S_ERR;
            end else if (!rx_sync_q) begin
              ecode_d = 2'b10;
              state_d = S_ERR;
            end else if (!frame_q) begin
              lo_d    = rsh_q[7:0];
              frame_d = 1'b1;
              tout_d  = '0;
              state_d = S_WAIT_START;
            end else begin
              data_d  = {rsh_q[7:0], lo_q};
              state_d = S_DONE;
            end
          end else begin
            rsh_d  = {rx_sync_q, rsh_q[8:1]};
            bidx_d = bidx_q + 4'd1;
          end
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tx         = (state_q == S_TX_ADDR) ? tsh_q[0] : 1'b1;
  assign tx_enable  = (state_q == S_TX_ADDR);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign data_valid = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign data_out   = data_q;
  assign err_code   = ecode_q;

endmodule

// File: tb/tb_rs485_master_poller.sv
// Directed bench for rs485_master_poller: address timing, timeout, good
// replies, framing errors, glitch rejection, reset mid-poll, minimum bit time.
module tb_rs485_master_poller;

  logic        clk = 1'b0;
  logic        rst, start, rx;
  logic [7:0]  slave_addr, clk_per_bit;
  logic        tx, tx_enable, busy, data_valid, error;
  logic [15:0] data_out;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt = 0, err_cnt = 0, both_cnt = 0;
  int d0, e0, n;

  rs485_master_poller #(.TIMEOUT_BITS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_addr(slave_addr),
    .clk_per_bit(clk_per_bit), .rx(rx), .tx(tx), .tx_enable(tx_enable),
    .busy(busy), .data_out(data_out), .data_valid(data_valid),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (error) err_cnt++;
    if (data_valid && error) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_te"}, tx_enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_dv"}, data_valid, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_ecode"}, err_code, 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic ninth, input logic stp, input int cpb);
    logic [10:0] f;
    f = {stp, ninth, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (cpb) tick();
    end
    rx = 1'b1;
  endtask

  task automatic poll_start(input logic [7:0] a, input logic [7:0] c);
    slave_addr  = a;
    clk_per_bit = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_txdone(input string tag);
    int k = 0;
    while (tx_enable && k < 5000) begin tick(); k++; end
    chk(tag, tx_enable, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 5000) begin tick(); k++; end
    chk(tag, busy, 0);
  endtask

  // Checks every cycle of the address frame; a start pulse during bit 3
  // (with a different address) must not disturb it.
  task automatic check_addr(input logic [7:0] a, input int cpb, input string tag);
    logic [10:0] f;
    int te = 0;
    f = {2'b11, a, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("%s_bit%0d", tag, k), tx, f[k]);
        if (tx_enable) te++;
        if (k == 3 && c == 0) begin start = 1'b1; slave_addr = 8'hFF; end
        else start = 1'b0;
        tick();
      end
    end
    chk({tag, "_te_cycles"}, te, 11 * cpb);
    chk({tag, "_te_off"}, tx_enable, 0);
    chk({tag, "_tx_idle"}, tx, 1);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic reply(input int gap, input int c,
                       input logic [7:0] lo, input logic n1, input logic s1,
                       input logic [7:0] hi, input logic n2, input logic s2,
                       input string tag);
    repeat (gap * c) tick();
    send_frame(lo, n1, s1, c);
    send_frame(hi, n2, s2, c);
    repeat (2 * c) tick();
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rx = 1'b1;
    slave_addr = 8'h00; clk_per_bit = 8'd25;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b1;
    tick();

    // address frame timing, then no reply -> timeout after 64 bit periods
    poll_start(8'h02, 8'd25);
    chk("addr_busy", busy, 1);
    chk("addr_te", tx_enable, 1);
    check_addr(8'h02, 25, "addr");
    e0 = err_cnt;
    n = 0;
    while (!error && n < 3000) begin tick(); n++; end
    chk("to_latency", n, 1600);
    chk("to_ecode", err_code, 2'b01);
    chk("to_dout", data_out, 0);
    chk("to_dv", data_valid, 0);
    chk("to_busy", busy, 0);
    tick();
    chk("to_pulse_end", error, 0);
    chk("to_pulses", err_cnt - e0, 1);

    // good reply 16'hA5C3
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h11, 8'd25);
    wait_txdone("good_txdone");
    reply(10, 25, 8'hC3, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, "good");
    chk("good_dv", dv_cnt - d0, 1);
    chk("good_noerr", err_cnt - e0, 0);
    chk("good_dout", data_out, 16'hA5C3);

    // frame 1 stop bit low
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h12, 8'd25);
    wait_txdone("stop_txdone");
    reply(3, 25, 8'hC3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, "stop");
    chk("stop_err", err_cnt - e0, 1);
    chk("stop_nodv", dv_cnt - d0, 0);
    chk("stop_ecode", err_code, 2'b10);
    chk("stop_dout", data_out, 16'hA5C3);

    // 9th bit high and stop low together: 9th-bit error wins
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h13, 8'd25);
    wait_txdone("both_txdone");
    reply(3, 25, 8'h33, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, "both");
    chk("both_err", err_cnt - e0, 1);
    chk("both_ecode", err_code, 2'b11);

    // frame 2 with 9th bit high
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h14, 8'd25);
    wait_txdone("ninth_txdone");
    reply(3, 25, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, "ninth");
    chk("ninth_err", err_cnt - e0, 1);
    chk("ninth_nodv", dv_cnt - d0, 0);
    chk("ninth_ecode", err_code, 2'b11);
    chk("ninth_dout", data_out, 16'hA5C3);

    // 5-clock glitch while waiting, then a valid reply
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h21, 8'd25);
    wait_txdone("glitch_txdone");
    repeat (75) tick();
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (125) tick();
    chk("glitch_busy", busy, 1);
    chk("glitch_noerr_yet", err_cnt - e0, 0);
    reply(0, 25, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, "glitch");
    chk("glitch_dv", dv_cnt - d0, 1);
    chk("glitch_dout", data_out, 16'h1234);
    chk("glitch_noerr", err_cnt - e0, 0);

    // reset in the middle of receiving a frame
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h22, 8'd25);
    wait_txdone("rstmid_txdone");
    repeat (50) tick();
    rx = 1'b0; repeat (25) tick();
    rx = 1'b1; repeat (25) tick();
    rx = 1'b0; repeat (25) tick();
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b0;
    tick();
    chk_reset_vals("rstmid");
    rst = 1'b1; rx = 1'b1;
    tick();
    chk("rstmid_nodv", dv_cnt - d0, 0);
    chk("rstmid_noerr", err_cnt - e0, 0);
    poll_start(8'h23, 8'd25);
    wait_txdone("fresh_txdone");
    reply(5, 25, 8'hEF, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1, "fresh");
    chk("fresh_dv", dv_cnt - d0, 1);
    chk("fresh_dout", data_out, 16'hBEEF);

    // clk_per_bit below the minimum runs at 4 clocks per bit
    d0 = dv_cnt; e0 = err_cnt;
    poll_start(8'h5A, 8'd2);
    chk("cpb2_busy", busy, 1);
    check_addr(8'h5A, 4, "cpb2");
    reply(10, 4, 8'h96, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, "cpb2");
    chk("cpb2_dv", dv_cnt - d0, 1);
    chk("cpb2_noerr", err_cnt - e0, 0);
    chk("cpb2_dout", data_out, 16'h3C96);

    chk("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
